// File: rtl/cpu_types_pkg.sv
// Shared CPU/bus types for the coherent bus controller.
//   word_t      : 32-bit bus word
//   ramstate_t  : memory handshake state returned by the RAM
//   bus_state_t : data-side coherence FSM states
//   wrap_inc    : modulo increment for round-robin pointers
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    SNOOP = 3'd2,
    MEMRD = 3'd3,
    C2C   = 3'd4,
    WB    = 3'd5,
    DONE  = 3'd6
  } bus_state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/coherent_bus_ctrl_if.sv
// Bundle of every cache-side and RAM-side signal of the coherent bus.
//   master : controller view (drives waits/loads, snoop broadcast, RAM request)
//   slave  : caches + RAM view (drive requests, snoop replies, RAM response)
interface coherent_bus_ctrl_if #(
  parameter int CPUS = 2
);
  import cpu_types_pkg::*;

  // instruction fetch
  logic  [CPUS-1:0] iREN;
  word_t [CPUS-1:0] iaddr;
  logic  [CPUS-1:0] iwait;
  word_t [CPUS-1:0] iload;
  // data
  logic  [CPUS-1:0] dREN;
  logic  [CPUS-1:0] dWEN;
  word_t [CPUS-1:0] daddr;
  word_t [CPUS-1:0] dstore;
  logic  [CPUS-1:0] dwait;
  word_t [CPUS-1:0] dload;
  // snoop
  logic  [CPUS-1:0] ccwrite;
  logic  [CPUS-1:0] ccdirty;
  logic  [CPUS-1:0] ccwait;
  logic  [CPUS-1:0] ccinv;
  word_t            ccsnoopaddr;
  // RAM
  logic             ramREN;
  logic             ramWEN;
  word_t            ramaddr;
  word_t            ramstore;
  word_t            ramload;
  ramstate_t        ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, ccdirty, ramload, ramstate,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, ccdirty, ramload, ramstate,
    input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/coherent_bus_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the requester closest at or after
// i_ptr (wrapping modulo N) wins.
//   i_req   : request vector
//   i_ptr   : highest-priority index this round
//   o_gnt   : winning index
//   o_valid : any request present
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
)(
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_gnt,
  output logic          o_valid
);

  int w_best;

  // Distance from the pointer decides priority; smallest distance wins.
  always_comb begin
    o_gnt   = '0;
    o_valid = 1'b0;
    w_best  = N;
    for (int j = 0; j < N; j++) begin
      if (i_req[j] && (((j - int'(i_ptr)) + N) % N) < w_best) begin
        w_best  = ((j - int'(i_ptr)) + N) % N;
        o_gnt   = IW'(j);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coherent_bus_ctrl.sv
// Snooping coherence bus controller for CPUS L1 I/D cache pairs sharing one RAM.
// Data side: one block transaction at a time (read from memory, cache-to-cache
// transfer from a Modified owner, or eviction write-back), round-robin granted.
// Instruction side: single-word fetches that use the RAM whenever the data FSM
// is not driving it, with their own round-robin.
//   CLK  : clock
//   nRST : synchronous active-low reset
//   bus  : coherent_bus_ctrl_if.master (caches + RAM)
module coherent_bus_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CPUS        = 2,
  parameter int BLOCK_WORDS = 2
)(
  input logic                 CLK,
  input logic                 nRST,
  coherent_bus_ctrl_if.master bus
);

  localparam int            IW        = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int            KW        = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam word_t         BASE_MASK = ~word_t'(BLOCK_WORDS * 4 - 1);
  localparam logic [KW-1:0] LAST_K    = KW'(BLOCK_WORDS - 1);

  bus_state_t    r_state;
  logic [IW-1:0] r_ptr, r_gnt, r_owner;
  logic [KW-1:0] r_k;
  word_t         r_base;
  logic          r_wr, r_ccw;
  logic [IW-1:0] r_iptr, r_ignt;
  logic          r_ivld;

  logic [CPUS-1:0] w_dreq;
  logic [IW-1:0]   w_dgnt, w_igrr, w_ig, w_owner;
  logic            w_dvld, w_irr_vld, w_iact, w_dram, w_iuse, w_access, w_owner_vld;
  word_t           w_addr;

  assign w_dreq   = bus.dREN | bus.dWEN;
  assign w_access = (bus.ramstate == ACCESS);
  assign w_addr   = r_base + word_t'({r_k, 2'b00});
  assign w_dram   = (r_state == MEMRD) || (r_state == C2C) || (r_state == WB);

  rr_arbiter #(.N(CPUS), .IW(IW)) u_darb (
    .i_req   (w_dreq),
    .i_ptr   (r_ptr),
    .o_gnt   (w_dgnt),
    .o_valid (w_dvld)
  );

  rr_arbiter #(.N(CPUS), .IW(IW)) u_iarb (
    .i_req   (bus.iREN),
    .i_ptr   (r_iptr),
    .o_gnt   (w_igrr),
    .o_valid (w_irr_vld)
  );

  // Once a fetch has been put on the RAM it keeps its grant until ACCESS,
  // even if data traffic pre-empts the RAM in between.
  assign w_ig   = r_ivld ? r_ignt : w_igrr;
  assign w_iact = r_ivld | w_irr_vld;
  assign w_iuse = nRST & ~w_dram & w_iact;

  // Lowest-numbered snooped cache (other than the requester) holding the block dirty.
  always_comb begin
    w_owner     = '0;
    w_owner_vld = 1'b0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      if (bus.ccdirty[i] && (IW'(i) != r_gnt)) begin
        w_owner     = IW'(i);
        w_owner_vld = 1'b1;
      end
    end
  end

  // Data coherence FSM
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_owner <= '0;
      r_k     <= '0;
      r_base  <= '0;
      r_wr    <= 1'b0;
      r_ccw   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (|w_dreq) r_state <= ARB;
        ARB: begin
          if (w_dvld) begin
            r_gnt  <= w_dgnt;
            r_base <= bus.daddr[w_dgnt] & BASE_MASK;
            r_wr   <= bus.dWEN[w_dgnt];
            r_ccw  <= bus.ccwrite[w_dgnt];
            r_k    <= '0;
            if (bus.dWEN[w_dgnt])  r_state <= WB;
            else if (CPUS == 1)    r_state <= MEMRD;
            else                   r_state <= SNOOP;
          end else begin
            // request withdrawn before it could be granted
            r_state <= IDLE;
          end
        end
        SNOOP: begin
          r_owner <= w_owner;
          r_state <= w_owner_vld ? C2C : MEMRD;
        end
        MEMRD, C2C, WB: begin
          // BUSY/ERROR leave k untouched so the same word is retried
          if (w_access) begin
            if (r_k == LAST_K) r_state <= DONE;
            else               r_k     <= r_k + KW'(1);
          end
        end
        DONE: begin
          r_ptr   <= IW'(wrap_inc(int'(r_gnt), CPUS));
          r_k     <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Instruction fetch grant tracking
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_iptr <= '0;
      r_ignt <= '0;
      r_ivld <= 1'b0;
    end else if (w_iuse) begin
      if (w_access) begin
        r_ivld <= 1'b0;
        r_iptr <= IW'(wrap_inc(int'(w_ig), CPUS));
      end else begin
        r_ivld <= 1'b1;
        r_ignt <= w_ig;
      end
    end
  end

  // Bus outputs. Held at their idle values whenever nRST is low so caches
  // and RAM see a quiet bus for the whole reset window.
  always_comb begin
    bus.iwait       = '1;
    bus.dwait       = '1;
    bus.iload       = '0;
    bus.dload       = '0;
    bus.ccwait      = '0;
    bus.ccinv       = '0;
    bus.ccsnoopaddr = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = '0;
    bus.ramstore    = '0;
    if (nRST) begin
      // Snooped caches stay frozen (and invalidating, for exclusive requests)
      // from the snoop until the block transaction retires.
      if (!r_wr && (r_state == SNOOP || r_state == MEMRD ||
                    r_state == C2C   || r_state == DONE)) begin
        for (int i = 0; i < CPUS; i++) begin
          if (IW'(i) != r_gnt) begin
            bus.ccwait[i] = 1'b1;
            bus.ccinv[i]  = r_ccw;
          end
        end
        bus.ccsnoopaddr = r_base;
      end
      case (r_state)
        MEMRD: begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = w_addr;
          if (w_access) begin
            bus.dload[r_gnt] = bus.ramload;
            bus.dwait[r_gnt] = 1'b0;
          end
        end
        C2C: begin
          // owner's data goes to the requester and to memory in the same beat
          bus.ramWEN   = 1'b1;
          bus.ramaddr  = w_addr;
          bus.ramstore = bus.dstore[r_owner];
          if (w_access) begin
            bus.dload[r_gnt]   = bus.dstore[r_owner];
            bus.dwait[r_gnt]   = 1'b0;
            bus.dwait[r_owner] = 1'b0;
          end
        end
        WB: begin
          bus.ramWEN   = 1'b1;
          bus.ramaddr  = w_addr;
          bus.ramstore = bus.dstore[r_gnt];
          if (w_access) bus.dwait[r_gnt] = 1'b0;
        end
        default: begin
          if (w_iuse) begin
            bus.ramREN  = 1'b1;
            bus.ramaddr = bus.iaddr[w_ig];
            if (w_access) begin
              bus.iwait[w_ig] = 1'b0;
              bus.iload[w_ig] = bus.ramload;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coherent_bus_ctrl.sv
// Directed bench: two controllers (BLOCK_WORDS=2 and BLOCK_WORDS=4, both CPUS=2)
// driven cycle by cycle; outputs checked 1ns after each falling edge.
module tb_coherent_bus_ctrl;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  int   total;
  int   bad;

  coherent_bus_ctrl_if #(.CPUS(2)) b2 ();
  coherent_bus_ctrl_if #(.CPUS(2)) b4 ();

  coherent_bus_ctrl #(.CPUS(2), .BLOCK_WORDS(2)) dut2 (.CLK(CLK), .nRST(nRST), .bus(b2));
  coherent_bus_ctrl #(.CPUS(2), .BLOCK_WORDS(4)) dut4 (.CLK(CLK), .nRST(nRST), .bus(b4));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    b2.iREN = '0; b2.iaddr = '0; b2.dREN = '0; b2.dWEN = '0; b2.daddr = '0; b2.dstore = '0;
    b2.ccwrite = '0; b2.ccdirty = '0; b2.ramload = '0; b2.ramstate = FREE;
    b4.iREN = '0; b4.iaddr = '0; b4.dREN = '0; b4.dWEN = '0; b4.daddr = '0; b4.dstore = '0;
    b4.ccwrite = '0; b4.ccdirty = '0; b4.ramload = '0; b4.ramstate = FREE;
  endtask

  logic [1:0] exp_ccw [3];
  word_t      exp_adr [3];

  initial begin
    total = 0;
    bad   = 0;
    exp_ccw = '{2'b10, 2'b01, 2'b10};
    exp_adr = '{32'h400, 32'h500, 32'h400};
    clear_inputs();
    nRST = 1'b0;

    // ---- reset: outputs quiet even with live requests and ACCESS
    @(negedge CLK);
    b2.dREN = 2'b01; b2.iREN = 2'b10; b2.ramstate = ACCESS; b2.ramload = 32'hFFFF;
    #1;
    chk("rst_iwait",  b2.iwait,  2'b11);
    chk("rst_dwait",  b2.dwait,  2'b11);
    chk("rst_ramREN", b2.ramREN, 1'b0);
    chk("rst_iload",  b2.iload,  64'h0);
    chk("rst_ccwait", b2.ccwait, 2'b00);
    @(negedge CLK);
    clear_inputs();

    // ---- memory read of block 0x100 by cpu0, BUSY 3 cycles on word 0
    @(negedge CLK);
    nRST = 1'b1; b2.dREN = 2'b01; b2.daddr[0] = 32'h104;
    #1;
    chk("idle_ramREN", b2.ramREN, 1'b0);
    chk("idle_dwait",  b2.dwait,  2'b11);
    @(negedge CLK); #1;                       // ARB
    chk("arb_ccwait", b2.ccwait, 2'b00);
    @(negedge CLK); #1;                       // SNOOP
    chk("snp_addr",   b2.ccsnoopaddr, 32'h100);
    chk("snp_ccwait", b2.ccwait, 2'b10);
    chk("snp_ccinv",  b2.ccinv,  2'b00);
    chk("snp_ramREN", b2.ramREN, 1'b0);
    @(negedge CLK); b2.ramstate = BUSY; #1;   // MEMRD k0
    chk("busy0_ren",   b2.ramREN,  1'b1);
    chk("busy0_addr",  b2.ramaddr, 32'h100);
    chk("busy0_dwait", b2.dwait,   2'b11);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); #1;
      chk("busy_addr",  b2.ramaddr, 32'h100);
      chk("busy_dwait", b2.dwait,   2'b11);
    end
    @(negedge CLK); b2.ramstate = ACCESS; b2.ramload = 32'h11; #1;
    chk("rd0_addr",   b2.ramaddr,  32'h100);
    chk("rd0_dwait",  b2.dwait,    2'b10);
    chk("rd0_dload0", b2.dload[0], 32'h11);
    chk("rd0_dload1", b2.dload[1], 32'h0);
    @(negedge CLK); b2.ramload = 32'h22; #1;  // MEMRD k1
    chk("rd1_addr",   b2.ramaddr,  32'h104);
    chk("rd1_dwait",  b2.dwait,    2'b10);
    chk("rd1_dload0", b2.dload[0], 32'h22);
    @(negedge CLK); b2.ramstate = FREE; b2.dREN = 2'b00; #1;   // DONE
    chk("done_ren",    b2.ramREN, 1'b0);
    chk("done_ccwait", b2.ccwait, 2'b10);
    chk("done_dwait",  b2.dwait,  2'b11);

    // ---- cpu1 exclusive read of 0x200, cpu0 owns it dirty -> C2C
    @(negedge CLK); b2.dREN = 2'b10; b2.ccwrite = 2'b10; b2.daddr[1] = 32'h200;
    @(negedge CLK);                           // ARB
    @(negedge CLK); b2.ccdirty = 2'b01; #1;   // SNOOP
    chk("c2c_snp_addr", b2.ccsnoopaddr, 32'h200);
    chk("c2c_snp_wait", b2.ccwait, 2'b01);
    chk("c2c_snp_inv",  b2.ccinv,  2'b01);
    @(negedge CLK);
    b2.ccdirty = 2'b00; b2.dstore[0] = 32'hAAAA; b2.dstore[1] = 32'h7777;
    b2.ramstate = ACCESS; b2.ramload = 32'hDEAD;
    #1;
    chk("c2c0_wen",   b2.ramWEN,   1'b1);
    chk("c2c0_ren",   b2.ramREN,   1'b0);
    chk("c2c0_addr",  b2.ramaddr,  32'h200);
    chk("c2c0_store", b2.ramstore, 32'hAAAA);
    chk("c2c0_dload", b2.dload[1], 32'hAAAA);
    chk("c2c0_dwait", b2.dwait,    2'b00);
    chk("c2c0_inv",   b2.ccinv,    2'b01);
    @(negedge CLK); b2.dstore[0] = 32'hBBBB; #1;
    chk("c2c1_addr",  b2.ramaddr,  32'h204);
    chk("c2c1_store", b2.ramstore, 32'hBBBB);
    chk("c2c1_dload", b2.dload[1], 32'hBBBB);
    chk("c2c1_inv",   b2.ccinv,    2'b01);
    @(negedge CLK);                           // DONE; queue both requesters next
    b2.ramstate = FREE; b2.ccwrite = 2'b00;
    b2.dREN = 2'b11; b2.daddr[0] = 32'h400; b2.daddr[1] = 32'h500;
    #1;
    chk("c2c_done_inv", b2.ccinv,  2'b01);
    chk("c2c_done_wen", b2.ramWEN, 1'b0);

    // ---- fairness: both held, expect cpu0, cpu1, cpu0
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 6; c++) begin
        @(negedge CLK);
        b2.ramstate = ACCESS;
        if (t == 2 && c == 5) begin
          b2.dREN = 2'b00;
          b2.ramstate = FREE;
        end
        #1;
        if (c == 2) chk("rr_grant", b2.ccwait, exp_ccw[t]);
        if (c == 3) chk("rr_addr",  b2.ramaddr, exp_adr[t]);
      end
    end

    // ---- reset in the middle of a C2C transfer
    @(negedge CLK); b2.dREN = 2'b01; b2.daddr[0] = 32'h600; b2.ccwrite = 2'b01;
    @(negedge CLK);                           // ARB
    @(negedge CLK); b2.ccdirty = 2'b10;       // SNOOP
    @(negedge CLK); b2.ccdirty = 2'b00; b2.ramstate = BUSY; b2.dstore[1] = 32'hCCCC; #1;
    chk("mid_wen",   b2.ramWEN,   1'b1);
    chk("mid_store", b2.ramstore, 32'hCCCC);
    chk("mid_addr",  b2.ramaddr,  32'h600);
    @(negedge CLK); nRST = 1'b0; #1;
    chk("mrst_wen",   b2.ramWEN,      1'b0);
    chk("mrst_addr",  b2.ramaddr,     32'h0);
    chk("mrst_store", b2.ramstore,    32'h0);
    chk("mrst_snp",   b2.ccsnoopaddr, 32'h0);
    chk("mrst_wait",  b2.ccwait,      2'b00);
    chk("mrst_inv",   b2.ccinv,       2'b00);
    chk("mrst_dwait", b2.dwait,       2'b11);
    chk("mrst_dload", b2.dload,       64'h0);
    @(negedge CLK);
    nRST = 1'b1; b2.dREN = 2'b11; b2.ccwrite = 2'b00;
    b2.daddr[0] = 32'h700; b2.daddr[1] = 32'h800; b2.ramstate = FREE;
    #1;
    chk("post_wen",   b2.ramWEN, 1'b0);
    chk("post_wait",  b2.ccwait, 2'b00);
    chk("post_inv",   b2.ccinv,  2'b00);
    chk("post_dwait", b2.dwait,  2'b11);
    @(negedge CLK);                           // ARB
    @(negedge CLK); #1;                       // SNOOP: pointer back at cpu0
    chk("post_gnt", b2.ccwait, 2'b10);
    @(negedge CLK); b2.ramstate = ACCESS; #1;
    chk("post_rd0", b2.ramaddr, 32'h700);
    @(negedge CLK); b2.dREN = 2'b00; #1;      // dropped request is ignored
    chk("post_rd1",   b2.ramaddr, 32'h704);
    chk("post_dwait1", b2.dwait,  2'b10);
    @(negedge CLK); b2.ramstate = FREE;       // DONE

    // ---- instruction fetch with idle data side
    @(negedge CLK); b2.iREN = 2'b10; b2.iaddr[1] = 32'h880; b2.ramstate = BUSY; #1;
    chk("if_ren",   b2.ramREN,  1'b1);
    chk("if_addr",  b2.ramaddr, 32'h880);
    chk("if_iwait", b2.iwait,   2'b11);
    @(negedge CLK); b2.ramstate = ACCESS; b2.ramload = 32'h1234; #1;
    chk("if_acc_iwait", b2.iwait,    2'b01);
    chk("if_iload1",    b2.iload[1], 32'h1234);
    chk("if_iload0",    b2.iload[0], 32'h0);
    @(negedge CLK); b2.iREN = 2'b00; b2.ramstate = FREE; #1;
    chk("if_end_ren", b2.ramREN, 1'b0);

    // ---- 4-word write-back by cpu1 while cpu0 fetches
    @(negedge CLK);
    b4.dWEN = 2'b10; b4.daddr[1] = 32'h30C; b4.iREN = 2'b01; b4.iaddr[0] = 32'h900;
    b4.ramstate = FREE;
    #1;
    chk("wb_idle_iwait", b4.iwait, 2'b11);
    @(negedge CLK); #1;                       // ARB
    chk("wb_arb_iwait", b4.iwait, 2'b11);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK); b4.ramstate = ACCESS; b4.dstore[1] = 32'hA0 + k; #1;
      chk("wb_wen",   b4.ramWEN,   1'b1);
      chk("wb_ren",   b4.ramREN,   1'b0);
      chk("wb_addr",  b4.ramaddr,  32'h300 + 4 * k);
      chk("wb_store", b4.ramstore, 32'hA0 + k);
      chk("wb_dwait", b4.dwait,    2'b01);
      chk("wb_iwait", b4.iwait,    2'b11);
    end
    @(negedge CLK); b4.dWEN = 2'b00; b4.ramload = 32'h5555; #1;   // DONE
    chk("wbf_ren",   b4.ramREN,    1'b1);
    chk("wbf_wen",   b4.ramWEN,    1'b0);
    chk("wbf_addr",  b4.ramaddr,   32'h900);
    chk("wbf_iwait", b4.iwait,     2'b10);
    chk("wbf_iload", b4.iload[0],  32'h5555);
    @(negedge CLK); b4.iREN = 2'b00; b4.ramstate = FREE; #1;
    chk("wbf_end_ren",   b4.ramREN, 1'b0);
    chk("wbf_end_iwait", b4.iwait,  2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
